// File: rtl/fp16_dot_accum.sv
// rtl/fp16_dot_accum.sv - FP16 four-lane product reducer and VEC_LEN-beat fixed-point dot-product accumulator
module fp16_dot_accum #(
    parameter int VEC_LEN = 4,
    parameter int FRAC    = 16,
    parameter int ACC_W   = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      qa,
    input  logic [15:0]      qb,
    input  logic [15:0]      qc,
    input  logic [15:0]      qd,
    input  logic             clear,
    output logic             out_valid,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);
    localparam int LANE_W = FRAC + 17;
    localparam int SUM_W  = LANE_W + 2;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    // Lane value is {1,mant} * 2^(exp-25+FRAC), truncated toward zero before the sign is applied.
    function automatic logic [LANE_W-1:0] fp_to_fix(input logic [15:0] f);
        logic [LANE_W-1:0] mag;
        int                sh;
        mag = {{(LANE_W-11){1'b0}}, 1'b1, f[9:0]};
        sh  = int'({27'd0, f[14:10]}) + FRAC - 25;
        if (sh >= 0) mag = mag << sh;
        else         mag = mag >> (-sh);
        if (f[14:10] == 5'd0 || f[14:10] == 5'd31) mag = '0;
        return f[15] ? (~mag + 1'b1) : mag;
    endfunction

    function automatic logic [SUM_W-1:0] sext_lane(input logic [LANE_W-1:0] v);
        return {{2{v[LANE_W-1]}}, v};
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1_valid_q, s1_valid_d, s1_special_q, s1_special_d;
    logic              s1_last_q, s1_last_d, s1_first_q, s1_first_d;
    logic [LANE_W-1:0] s1_lane_q [4];
    logic [LANE_W-1:0] s1_lane_d [4];
    logic              s2_valid_q, s2_valid_d, s2_special_q, s2_special_d;
    logic              s2_last_q, s2_last_d, s2_first_q, s2_first_d;
    logic [ACC_W-1:0]  s2_sum_q, s2_sum_d;
    logic              s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic              out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [ACC_W-1:0]  result_q, result_d;

    logic              last_in;
    logic [SUM_W-1:0]  lane_sum;
    logic [ACC_W-1:0]  acc_base;
    logic              sticky_base;

    always_comb begin
        last_in      = (cnt_q == CNT_W'(VEC_LEN - 1));
        cnt_d        = cnt_q;
        if (clear)         cnt_d = '0;
        else if (in_valid) cnt_d = last_in ? '0 : cnt_q + 1'b1;

        s1_valid_d   = in_valid & ~clear;
        s1_last_d    = last_in;
        s1_first_d   = (cnt_q == '0);
        s1_lane_d[0] = fp_to_fix(qa);
        s1_lane_d[1] = fp_to_fix(qb);
        s1_lane_d[2] = fp_to_fix(qc);
        s1_lane_d[3] = fp_to_fix(qd);
        s1_special_d = (&qa[14:10]) | (&qb[14:10]) | (&qc[14:10]) | (&qd[14:10]);

        lane_sum     = sext_lane(s1_lane_q[0]) + sext_lane(s1_lane_q[1])
                     + sext_lane(s1_lane_q[2]) + sext_lane(s1_lane_q[3]);
        s2_valid_d   = s1_valid_q & ~clear;
        s2_sum_d     = {{(ACC_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
        s2_special_d = s1_special_q;
        s2_last_d    = s1_last_q;
        s2_first_d   = s1_first_q;

        // The first beat of a group restarts both the sum and the sticky overflow.
        acc_base     = s2_first_q ? '0 : acc_q;
        sticky_base  = s2_first_q ? 1'b0 : sticky_q;
        acc_d        = acc_q;
        sticky_d     = sticky_q;
        s3_valid_d   = 1'b0;
        s3_last_d    = s3_last_q;
        if (s2_valid_q && !clear) begin
            acc_d      = acc_base + s2_sum_q;
            sticky_d   = sticky_base | s2_special_q
                       | ((acc_base[ACC_W-1] == s2_sum_q[ACC_W-1]) &&
                          (acc_d[ACC_W-1] != acc_base[ACC_W-1]));
            s3_valid_d = 1'b1;
            s3_last_d  = s2_last_q;
        end

        out_valid_d  = s3_valid_q & s3_last_q;
        result_d     = out_valid_d ? acc_q : result_q;
        ovf_d        = out_valid_d ? sticky_q : ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_special_q <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_first_q   <= 1'b0;
            for (int i = 0; i < 4; i++) s1_lane_q[i] <= '0;
            s2_valid_q   <= 1'b0;
            s2_special_q <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_sum_q     <= '0;
            s3_valid_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            acc_q        <= '0;
            sticky_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_special_q <= s1_special_d;
            s1_last_q    <= s1_last_d;
            s1_first_q   <= s1_first_d;
            for (int i = 0; i < 4; i++) s1_lane_q[i] <= s1_lane_d[i];
            s2_valid_q   <= s2_valid_d;
            s2_special_q <= s2_special_d;
            s2_last_q    <= s2_last_d;
            s2_first_q   <= s2_first_d;
            s2_sum_q     <= s2_sum_d;
            s3_valid_q   <= s3_valid_d;
            s3_last_q    <= s3_last_d;
            acc_q        <= acc_d;
            sticky_q     <= sticky_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_fp16_dot_accum.sv
// tb/tb_fp16_dot_accum.sv - directed self-checking bench for fp16_dot_accum
module tb_fp16_dot_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] qa, qb, qc, qd;
    logic        clear;
    logic        out_valid;
    logic [47:0] result;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_edge;
    int first_last;

    int          p_cyc [$];
    logic [47:0] p_res [$];
    logic        p_ovf [$];

    fp16_dot_accum #(.VEC_LEN(4), .FRAC(16), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .qa(qa), .qb(qb), .qc(qc), .qd(qd), .clear(clear),
        .out_valid(out_valid), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records every pulse with the edge count it followed.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            p_cyc.push_back(cyc);
            p_res.push_back(result);
            p_ovf.push_back(ovf);
        end
    end

    task automatic beat(input logic [15:0] a, b, c, d);
        @(negedge clk);
        in_valid = 1'b1; clear = 1'b0;
        qa = a; qb = b; qc = c; qd = d;
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; clear = 1'b0;
        end
    endtask

    task automatic flush_queues();
        p_cyc.delete(); p_res.delete(); p_ovf.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
        qa = '0; qb = '0; qc = '0; qd = '0;
        @(negedge clk);
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        if (result !== 48'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_ones();
        flush_queues();
        for (int i = 0; i < 4; i++) beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 1) begin n_fail++; $display("FAIL ones_count got=%0d want=1", p_cyc.size()); end
        else begin
            n_cmp += 3;
            if (p_cyc[0] !== last_edge + 3) begin n_fail++; $display("FAIL ones_latency got=%0d want=%0d", p_cyc[0], last_edge + 3); end
            if (p_res[0] !== 48'h100000) begin n_fail++; $display("FAIL ones_result got=%h want=100000", p_res[0]); end
            if (p_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ones_ovf got=%0b want=0", p_ovf[0]); end
        end
    endtask

    task automatic test_mixed(input int gap);
        flush_queues();
        for (int i = 0; i < 4; i++) begin
            beat(16'h4600, 16'hC200, 16'h4000, 16'hC400);
            if (gap > 0 && i < 3) idle(1 + ((i + gap) % 3));
        end
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 1) begin n_fail++; $display("FAIL mixed_count gap=%0d got=%0d want=1", gap, p_cyc.size()); end
        else begin
            n_cmp += 3;
            if (p_cyc[0] !== last_edge + 3) begin n_fail++; $display("FAIL mixed_latency gap=%0d got=%0d want=%0d", gap, p_cyc[0], last_edge + 3); end
            if (p_res[0] !== 48'h40000) begin n_fail++; $display("FAIL mixed_result gap=%0d got=%h want=40000", gap, p_res[0]); end
            if (p_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL mixed_ovf gap=%0d got=%0b want=0", gap, p_ovf[0]); end
        end
    endtask

    task automatic test_back_to_back();
        flush_queues();
        for (int i = 0; i < 4; i++) beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        first_last = last_edge;
        for (int i = 0; i < 4; i++) beat(16'hBC00, 16'h0001, 16'h0001, 16'h0000);
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d want=2", p_cyc.size()); end
        else begin
            n_cmp += 6;
            if (p_cyc[0] !== first_last + 3) begin n_fail++; $display("FAIL b2b_latency got=%0d want=%0d", p_cyc[0], first_last + 3); end
            if (p_cyc[1] - p_cyc[0] !== 4) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=4", p_cyc[1] - p_cyc[0]); end
            if (p_res[0] !== 48'h100000) begin n_fail++; $display("FAIL b2b_result0 got=%h want=100000", p_res[0]); end
            if (p_res[1] !== 48'hFFFFFFFC0000) begin n_fail++; $display("FAIL b2b_result1 got=%h want=fffffffc0000", p_res[1]); end
            if (p_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf0 got=%0b want=0", p_ovf[0]); end
            if (p_ovf[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf1 got=%0b want=0", p_ovf[1]); end
        end
    endtask

    task automatic test_special();
        flush_queues();
        beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        beat(16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00);
        beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        for (int i = 0; i < 4; i++) beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 2) begin n_fail++; $display("FAIL special_count got=%0d want=2", p_cyc.size()); end
        else begin
            n_cmp += 4;
            if (p_res[0] !== 48'hF0000) begin n_fail++; $display("FAIL special_result0 got=%h want=f0000", p_res[0]); end
            if (p_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL special_ovf0 got=%0b want=1", p_ovf[0]); end
            if (p_res[1] !== 48'h100000) begin n_fail++; $display("FAIL special_result1 got=%h want=100000", p_res[1]); end
            if (p_ovf[1] !== 1'b0) begin n_fail++; $display("FAIL special_ovf1 got=%0b want=0", p_ovf[1]); end
        end
    endtask

    task automatic test_small_values();
        // 0x1401 -> 64 (truncated), 0x0400 -> 4 (minimum normal), 0x8400 -> -4, 0x0001 -> 0
        flush_queues();
        for (int i = 0; i < 4; i++) beat(16'h1401, 16'h0400, 16'h0001, 16'h8400);
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 1) begin n_fail++; $display("FAIL small_count got=%0d want=1", p_cyc.size()); end
        else begin
            n_cmp += 2;
            if (p_res[0] !== 48'h100) begin n_fail++; $display("FAIL small_result got=%h want=100", p_res[0]); end
            if (p_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL small_ovf got=%0b want=0", p_ovf[0]); end
        end
    endtask

    task automatic test_mid_reset();
        flush_queues();
        beat(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        beat(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%0b want=0", out_valid); end
        if (result !== 48'h0) begin n_fail++; $display("FAIL midrst_result got=%h want=0", result); end
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf got=%0b want=0", ovf); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 1) begin n_fail++; $display("FAIL midrst_count got=%0d want=1", p_cyc.size()); end
        else begin
            n_cmp += 2;
            if (p_cyc[0] !== last_edge + 3) begin n_fail++; $display("FAIL midrst_latency got=%0d want=%0d", p_cyc[0], last_edge + 3); end
            if (p_res[0] !== 48'h100000) begin n_fail++; $display("FAIL midrst_result2 got=%h want=100000", p_res[0]); end
        end
    endtask

    task automatic test_clear();
        flush_queues();
        beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        @(negedge clk);
        in_valid = 1'b1; clear = 1'b1;
        for (int i = 0; i < 4; i++) beat(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        idle(8);
        n_cmp++;
        if (p_cyc.size() !== 1) begin n_fail++; $display("FAIL clear_count got=%0d want=1", p_cyc.size()); end
        else begin
            n_cmp += 3;
            if (p_cyc[0] !== last_edge + 3) begin n_fail++; $display("FAIL clear_latency got=%0d want=%0d", p_cyc[0], last_edge + 3); end
            if (p_res[0] !== 48'h200000) begin n_fail++; $display("FAIL clear_result got=%h want=200000", p_res[0]); end
            if (p_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL clear_ovf got=%0b want=0", p_ovf[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_mixed(0);
        test_mixed(1);
        test_back_to_back();
        test_special();
        test_small_values();
        test_mid_reset();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
